// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, oversampling constants, frame shape
// and the wire-order bit map used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP1,
    RX_STOP2
  } rx_state_e;

  typedef enum logic [1:0] {
    HS_EMPTY,
    HS_REQ,
    HS_RELEASE
  } hs_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int SMP_W      = $clog2(OVERSAMPLE);

  // Mid-bit sample points; decisions are always taken at the late point so
  // the majority-vote and single-sample builds share identical timing.
  localparam logic [SMP_W-1:0] SMP_EARLY = SMP_W'(6);
  localparam logic [SMP_W-1:0] SMP_MID   = SMP_W'(7);
  localparam logic [SMP_W-1:0] SMP_LATE  = SMP_W'(8);

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 2;

  // Wire bit index 0..7 carries data positions 1..7 then 0.
  function automatic logic [2:0] bit_pos(input logic [2:0] idx);
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running divider that pulses tick_o for one clock every DIV clocks.
module uart_tick_gen #(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic clr,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver with a req/ack holding register.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 voting at each mid-bit decision.
module uart_receiver #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DIV        = CLK_HZ / (BAUD * OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rcv,
  output logic [7:0] data,
  output logic       req,
  input  logic       ack,
  output logic       ferr,
  output logic       ovr
);

  import uart_pkg::*;

  logic            tick;
  logic            rcv_meta_q, rcv_sync_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [SMP_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            armed_q, armed_d;
  logic            ferr_q, ferr_d;
  hs_state_e       hs_state_q, hs_state_d;
  logic [7:0]      hold_q, hold_d;
  logic            ovr_q, ovr_d;
  logic            commit;
  logic            samp_tick;
  logic            bit_val;
  logic            v7_q;

  uart_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .clr   (clr),
    .tick_o(tick)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rcv_meta_q <= 1'b1;
      rcv_sync_q <= 1'b1;
    end else begin
      rcv_meta_q <= rcv;
      rcv_sync_q <= rcv_meta_q;
    end
  end

  assign samp_tick = tick && (rx_state_q != RX_IDLE);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      v7_q <= 1'b1;
    end else if (samp_tick && smp_cnt_q == SMP_MID) begin
      v7_q <= rcv_sync_q;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic v6_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      v6_q <= 1'b1;
    end else if (samp_tick && smp_cnt_q == SMP_EARLY) begin
      v6_q <= rcv_sync_q;
    end
  end

  assign bit_val = (v6_q & v7_q) | (v6_q & rcv_sync_q) | (v7_q & rcv_sync_q);
`else
  assign bit_val = v7_q;
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    smp_cnt_d  = smp_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    armed_d    = armed_q | rcv_sync_q;
    ferr_d     = 1'b0;
    commit     = 1'b0;
    if (tick) begin
      if (rx_state_q == RX_IDLE) begin
        // After a framing error the line must return high before re-arming.
        if (!rcv_sync_q && armed_q) begin
          rx_state_d = RX_START;
          smp_cnt_d  = '0;
        end
      end else begin
        smp_cnt_d = smp_cnt_q + 1'b1;
        if (smp_cnt_q == SMP_LATE) begin
          case (rx_state_q)
            RX_START: begin
              if (bit_val) begin
                rx_state_d = RX_IDLE;
              end else begin
                rx_state_d = RX_DATA;
                bit_idx_d  = '0;
              end
            end
            RX_DATA: begin
              shift_d[bit_pos(bit_idx_q)] = bit_val;
              bit_idx_d = bit_idx_q + 3'd1;
              if (bit_idx_q == 3'(DATA_BITS - 1)) rx_state_d = RX_STOP1;
            end
            RX_STOP1, RX_STOP2: begin
              if (!bit_val) begin
                ferr_d     = 1'b1;
                armed_d    = 1'b0;
                rx_state_d = RX_IDLE;
              end else if (rx_state_q == RX_STOP2) begin
                commit     = 1'b1;
                rx_state_d = RX_IDLE;
              end else begin
                rx_state_d = RX_STOP2;
              end
            end
            default: rx_state_d = RX_IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    hs_state_d = hs_state_q;
    hold_d     = hold_q;
    ovr_d      = 1'b0;
    case (hs_state_q)
      HS_EMPTY: begin
        if (commit) begin
          hold_d     = shift_q;
          hs_state_d = HS_REQ;
        end
      end
      HS_REQ:     if (ack) hs_state_d = HS_RELEASE;
      HS_RELEASE: if (!ack) hs_state_d = HS_EMPTY;
      default:    hs_state_d = HS_EMPTY;
    endcase
    // A frame finishing while the slot is owned by the consumer is lost.
    if (commit && hs_state_q != HS_EMPTY) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rx_state_q <= RX_IDLE;
      smp_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      armed_q    <= 1'b1;
      ferr_q     <= 1'b0;
      hs_state_q <= HS_EMPTY;
      hold_q     <= '0;
      ovr_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      smp_cnt_q  <= smp_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      armed_q    <= armed_d;
      ferr_q     <= ferr_d;
      hs_state_q <= hs_state_d;
      hold_q     <= hold_d;
      ovr_q      <= ovr_d;
    end
  end

  assign data = hold_q;
  assign req  = (hs_state_q == HS_REQ);
  assign ferr = ferr_q;
  assign ovr  = ovr_q;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver; the receive end of the team's 9600-baud serial link.
- Oversamples the `rcv` line 16x, frames and validates one byte, then hands it to the consumer over a 4-phase `req`/`ack` handshake.
- Sits between the board RX pin and the consuming logic, such as a command decoder.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- BAUD, 9600, line bit rate.
- OVERSAMPLE, 16, ticks per bit.
- DIV, CLK_HZ/(BAUD*OVERSAMPLE) = 325, clocks per tick. Overridable; simulation uses 4.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-low.
- rcv  in  1  serial line. Idles high. Asynchronous to clk.
- data  out  8  received byte. Valid while req=1.
- req  out  1  byte available to the consumer.
- ack  in  1  consumer handshake.
- ferr  out  1  one-cycle pulse: framing error (stop bit low).
- ovr  out  1  one-cycle pulse: completed frame dropped because the holding register was full.

Behaviour:
- Reset (clr=0, async):
  - Outputs: req=0, data=0, ferr=0, ovr=0.
  - Internal: both FSMs to IDLE/EMPTY, tick and bit counters cleared, synchronizer flops set to 1.
  - Reset mid-frame discards the partial byte. The next valid frame is received normally.
- Input conditioning: `rcv` passes through a 2-flop synchronizer. All sampling uses the synchronized value (2-cycle input latency).
- Tick generator: pulses `tick` for one clk every DIV clocks. Free-running, cleared only by reset.
- Frame format: 1 start bit (0), 8 data bits, 2 stop bits (1), no parity.
  - Wire order is data[1], data[2], data[3], data[4], data[5], data[6], data[7], data[0].
  - The receiver reassembles the byte into normal bit positions.
- Receive FSM states: IDLE, START, DATA, STOP1, STOP2.
  - IDLE: waits for synchronized rcv=0 on a tick, then goes to START with sample counter=0.
  - START: at sample count 7 (mid-bit), rcv=0 → DATA with bit index=0; rcv=1 → IDLE (false start, no error flagged).
  - DATA: samples every 16 ticks at mid-bit. Bit index 0..7 maps to data positions 1..7,0. After index 7 → STOP1.
  - STOP1 / STOP2: mid-bit sample. Sample 0 → ferr pulse, frame discarded, go to IDLE. Line must be seen high before a new start is accepted.
  - STOP2 sample 1 → commit byte, go to IDLE.
- Commit and handshake:
  - Handshake FSM states: EMPTY, REQ, RELEASE.
  - Commit while EMPTY: the holding register loads the shift register; req rises the next clk (state REQ).
  - Commit while REQ or RELEASE: byte dropped, ovr pulses one clk, holding register unchanged.
  - REQ: req=1, data stable. On ack=1 → RELEASE with req=0.
  - RELEASE: wait for ack=0 → EMPTY.
  - ack=1 seen while EMPTY is ignored.
  - Receive FSM runs independently of the handshake FSM; a frame can arrive during the handshake.
- Simultaneous events: commit and ack=0 in the same clk while in RELEASE counts as full; the byte is dropped and ovr pulses.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined: each mid-bit decision, including start verify and stop bits, is the 2-of-3 majority of samples at counts 6, 7, 8.
- Undefined: single sample at count 7.
- Ports and timing are identical either way.

Decomposition:
- Shared package uart_pkg holds:
  - receive-state and handshake-state encodings;
  - OVERSAMPLE and the mid-sample index constants;
  - frame constants: data bits = 8, stop bits = 2;
  - the bit-index-to-data-position map, shared with the transmitter.
- Natural sub-module: uart_tick_gen (DIV counter producing `tick`), reusable by the transmitter.

Test Plan (DIV=4, so 64 clk per bit):
- Frame 0xA5 in wire order, ack held low → req=1 and data=0xA5 within 2+~64 clk after the STOP2 midpoint. Raise ack → req=0 next clk. Drop ack → a subsequent frame 0x3C is received.
- rcv low pulse of 20 clk (shorter than half a bit) → no req, no ferr; FSM back in IDLE.
- Frame 0x55 with STOP1 driven low → ferr pulses once, req stays 0, data keeps its previous value.
- Frames 0x11 then 0x22 back-to-back with ack held low → req=1, data=0x11, ovr pulses once at the second commit.
- clr=0 for 3 clk during DATA bit 4 → all outputs 0 immediately (asynchronous). Next frame 0xF0 → data=0xF0.
- One-clk-wide glitch to 1 exactly at sample count 7 of a 0 data bit:
  - with UART_RX_MAJORITY_VOTE_EN → correct byte;
  - without it → that bit reads 1.
